// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and hardwired-zero x0.
// Zero-latency reads (optional same-cycle write bypass); writes, allocs, flush and reset take effect on the rising edge.
module regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int ADDR   = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NREAD*ADDR-1:0]   rd_addr_i,
    output logic [NREAD*WIDTH-1:0]  rd_data_o,
    output logic [NREAD-1:0]        rd_busy_o,
    input  logic [NWRITE-1:0]       wr_en_i,
    input  logic [NWRITE*ADDR-1:0]  wr_addr_i,
    input  logic [NWRITE*WIDTH-1:0] wr_data_i,
    input  logic                    alloc_en_i,
    input  logic [ADDR-1:0]         alloc_addr_i,
    input  logic                    flush_i
);
    localparam int NENTRY = 2**ADDR;

    if (NREAD < 1)  begin : g_bad_nread  $error("regfile_mp: NREAD must be >= 1");  end
    if (NWRITE < 1) begin : g_bad_nwrite $error("regfile_mp: NWRITE must be >= 1"); end
    if (ADDR < 1)   begin : g_bad_addr   $error("regfile_mp: ADDR must be >= 1");   end

    logic [WIDTH-1:0]  data_q [NENTRY];
    logic [WIDTH-1:0]  data_d [NENTRY];
    logic [NENTRY-1:0] busy_q;
    logic [NENTRY-1:0] busy_d;

    // Ascending port order lets the highest-index writer win; busy priority is
    // applied lowest first (write-clear, then flush, then alloc) so later stages override.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR +: ADDR] != '0)) begin
                data_d[wr_addr_i[j*ADDR +: ADDR]] = wr_data_i[j*WIDTH +: WIDTH];
                busy_d[wr_addr_i[j*ADDR +: ADDR]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (alloc_en_i && (alloc_addr_i != '0)) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        data_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NENTRY; k++) begin
                data_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR-1:0] ra;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = rd_addr_i[i*ADDR +: ADDR];
            rd_data_o[i*WIDTH +: WIDTH] = data_q[ra];
            rd_busy_o[i] = busy_q[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*ADDR +: ADDR] == ra)) begin
                        rd_data_o[i*WIDTH +: WIDTH] = wr_data_i[j*WIDTH +: WIDTH];
                        rd_busy_o[i] = 1'b0;
                    end
                end
            end
            if (ra == '0) begin
                rd_data_o[i*WIDTH +: WIDTH] = '0;
                rd_busy_o[i] = 1'b0;
            end
        end
    end
endmodule
